// File: rtl/freq_counter.sv
// Gated frequency counter: synchronises sigIn, counts its rising edges over a
// fixed gate window in saturating 4-digit BCD, and latches the result per window.
module freq_counter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int GATE_W      = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sigIn,
  output logic [15:0] bcdOut,
  output logic        overRange,
  output logic        dataValid
);

  typedef enum logic [1:0] {
    ST_GATE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic              w_rise;
  state_t            r_state;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [15:0]       r_bcd;
  logic              r_ovf;

  // Ripple-carry BCD increment; the caller guarantees the input is below 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          res[i*4 +: 4] = 4'd0;
          carry         = 1'b1;
        end else begin
          res[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end else begin
        res[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return res;
  endfunction

  assign w_rise = r_s2 & ~r_s3;

  // Three-flop synchroniser; only r_s1 may go metastable, r_s3 is the edge-detect delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sigIn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Gate/latch/clear sequencer with the BCD accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_GATE;
      r_gate_cnt <= '0;
      r_bcd      <= 16'h0000;
      r_ovf      <= 1'b0;
      bcdOut     <= 16'h0000;
      overRange  <= 1'b0;
      dataValid  <= 1'b0;
    end else begin
      dataValid <= 1'b0;
      case (r_state)
        ST_GATE: begin
          // Saturate at 9999 instead of wrapping; the flag stays set until CLEAR.
          if (w_rise) begin
            if (r_bcd == 16'h9999) begin
              r_ovf <= 1'b1;
            end else begin
              r_bcd <= bcd_inc(r_bcd);
            end
          end
          if (r_gate_cnt == GATE_LAST) begin
            r_state <= ST_LATCH;
          end else begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
          end
        end
        ST_LATCH: begin
          bcdOut    <= r_bcd;
          overRange <= r_ovf;
          dataValid <= 1'b1;
          r_state   <= ST_CLEAR;
        end
        ST_CLEAR: begin
          r_bcd      <= 16'h0000;
          r_ovf      <= 1'b0;
          r_gate_cnt <= '0;
          r_state    <= ST_GATE;
        end
        default: begin
          r_bcd      <= 16'h0000;
          r_ovf      <= 1'b0;
          r_gate_cnt <= '0;
          r_state    <= ST_GATE;
        end
      endcase
    end
  end

endmodule

// File: doc/freq_counter.md
# freq_counter

Gated frequency counter that consumes the range-selected test signal from the frequency-range stage and turns it into a 4-digit BCD reading. It synchronises the asynchronous input to the system clock and counts its rising edges during a fixed gate window. At the end of each window it latches the count, flags over-range, then clears and starts the next window. Its outputs feed the display/decoder stage.

## Interface
- GATE_CYCLES, default 50_000_000: gate window length in clk cycles; 1 s at 50 MHz; minimum 4.
- GATE_W, default 26: width of the gate counter; must satisfy 2^GATE_W > GATE_CYCLES.
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- sigIn  input  1  signal under test from the range stage; asynchronous to clk.
- bcdOut  output  16  latched count, four BCD digits; [15:12] is thousands, [3:0] is units.
- overRange  output  1  latched: the last window had more than 9999 edges.
- dataValid  output  1  one-cycle pulse when bcdOut and overRange update.

## Operation
- **Input synchroniser.** sigIn passes through three flops, s1 → s2 → s3. The edge pulse is rise = s2 & ~s3. Only s1 may go metastable.
- **State machine.** Three states:
  - GATE: the gate counter runs from 0 to GATE_CYCLES-1. When it reaches GATE_CYCLES-1, go to LATCH.
  - LATCH: lasts one cycle. Copy the BCD count to bcdOut and the overflow flag to overRange. Assert dataValid on the following cycle. Go to CLEAR.
  - CLEAR: lasts one cycle. Zero the BCD count, the overflow flag and the gate counter. Go to GATE.
- **Counting.**
  - Count only in GATE, and only when rise=1.
  - The rise pulse that coincides with the last GATE cycle is still counted.
  - Rise pulses during LATCH or CLEAR are dropped.
- **BCD arithmetic.**
  - Each digit counts 0 to 9. When a digit wraps from 9 to 0, it carries into the next digit.
  - An increment at 9999 does not wrap. The count holds at 9999 and the sticky overflow flag is set.
- **Reset.**
  - Asserting rst_n at any time, including mid-window, aborts the window and discards the partial count.
  - Reset values: bcdOut=16'h0000, overRange=0, dataValid=0, all synchroniser flops=0, state=GATE, gate counter=0.
- **Register behaviour.** bcdOut and overRange are registers. They change only on the cycle dataValid is high, or on reset.

## Timing
- **Measurement period.** Exactly GATE_CYCLES+2 clk cycles per measurement.
- **First result after reset.** Take cycle 0 as the first rising edge with rst_n high. Then:
  - GATE covers cycles 0 to GATE_CYCLES-1.
  - LATCH is at cycle GATE_CYCLES.
  - dataValid and the new bcdOut appear in cycle GATE_CYCLES+1, which is also CLEAR.
  - The next GATE starts at cycle GATE_CYCLES+2.
- **Edge latency.** A sigIn rising edge is sampled into s1 on clk edge k. rise is high after edge k+1. The count increments on edge k+2.
- **Input limits.** sigIn high and low phases must each be at least one clk period. The maximum countable rate is clk/2. Faster inputs may lose edges; this is not flagged.
- **Window tolerance.** The count equals the number of rise pulses seen in GATE cycles. Relative to the true sigIn frequency, the reading is within ±1 of the true edge count.
- **dataValid width.** Exactly one clk cycle wide; never asserted two cycles in a row.

## Test plan
1. **Nominal reading.** GATE_CYCLES=100, sigIn period 10 clk, started at cycle 3. Required: dataValid at cycle 101 and bcdOut=16'h0010 (16'h0009 or 16'h0011 accepted for window phase). overRange=0. Later pulses repeat every 102 cycles.
2. **Idle input.** sigIn held at 0. Required: every dataValid shows bcdOut=16'h0000 and overRange=0.
3. **BCD carry chain.** GATE_CYCLES=2000, sigIn period 2 clk. Required: bcdOut=16'h1000 ±1 count, so 16'h0999 or 16'h1001 also pass. No digit may be above 9 at any point.
4. **Overflow saturation.** GATE_CYCLES=30000, sigIn period 2 clk (about 15000 edges). Required: bcdOut=16'h9999 and overRange=1. The next window with sigIn=0 gives 16'h0000 and overRange=0, which shows the sticky flag was cleared.
5. **Reset mid-window.** GATE_CYCLES=100, sigIn period 4 clk. Pull rst_n low at cycle 50 for 3 cycles. Required:
   - Outputs go to 0 immediately, without waiting for clk.
   - No dataValid during reset.
   - The first dataValid comes 101 cycles after rst_n is released, with bcdOut=16'h0025 ±1.
6. **Edge at window boundary.** Place a single sigIn rising edge so its rise pulse lands on the last GATE cycle. Required: count=16'h0001. Move the edge one cycle later, into LATCH. Required: count=16'h0000 and the next window count=16'h0000.
